// File: rtl/pcie_egress_sched.sv
// pcie_egress_sched
//   Round-robin scheduler sharing one PCIe egress packet engine among four
//   requesters. Picks a winner, latches its TLP header fields, runs the
//   engine enable/finished handshake and steers the engine data-FIFO mux.
//
// Ports
//   clk, rst                  core clock, asynchronous active-high reset
//   i_sched_en                global enable (blocks new grants only)
//   i_req                     per-requester level request
//   i_req_*                   packed per-requester header fields
//   o_grant, o_fifo_sel       one-hot grant and index of granted requester
//   o_done                    one-cycle completion pulse to the winner
//   o_egress_enable, o_egress_*, i_egress_finished   engine handshake/header
//   o_busy, o_tx_count        status
//   o_timeout                 one-cycle engine-timeout pulse
//
// Optional feature: define PCIE_EGRESS_SCHED_TIMEOUT_EN to add a BUSY
// watchdog of TIMEOUT cycles; otherwise BUSY waits forever, o_timeout = 0.
//
// state   | meaning
// IDLE    | waiting for an enabled request with the engine not finished
// BUSY    | engine enabled, waiting for finished
// RELEASE | engine done, waiting for finished to drop before o_done

module pcie_egress_sched #(
   parameter int          NUM_REQ = 4,
   parameter logic [15:0] TIMEOUT = 16'hFFFF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_sched_en,
   input  logic [3:0]   i_req,
   input  logic [31:0]  i_req_command,
   input  logic [55:0]  i_req_flags,
   input  logic [127:0] i_req_address,
   input  logic [63:0]  i_req_requester_id,
   input  logic [31:0]  i_req_tag,
   input  logic [39:0]  i_req_dword_cnt,
   output logic [3:0]   o_grant,
   output logic [3:0]   o_done,
   output logic [1:0]   o_fifo_sel,
   output logic         o_egress_enable,
   output logic [7:0]   o_egress_command,
   output logic [13:0]  o_egress_flags,
   output logic [31:0]  o_egress_address,
   output logic [15:0]  o_egress_requester_id,
   output logic [7:0]   o_egress_tag,
   output logic [9:0]   o_egress_req_dword_cnt,
   input  logic         i_egress_finished,
   output logic         o_busy,
   output logic [31:0]  o_tx_count,
   output logic         o_timeout
);

   typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

   state_t     state;
   logic [1:0] r_last;
   logic [1:0] winner;
   logic       found;
   logic [1:0] idx;

   // Search starts one past the last winner; the final probe (i == NUM_REQ)
   // revisits the last winner itself so a lone requester can win again.
   always_comb begin
      winner = r_last;
      found  = 1'b0;
      idx    = r_last;
      for (int i = 1; i <= NUM_REQ; i++) begin
         idx = r_last + 2'(i);
         if (!found && i_req[idx]) begin
            winner = idx;
            found  = 1'b1;
         end
      end
   end

`ifdef PCIE_EGRESS_SCHED_TIMEOUT_EN
   logic [15:0] r_cnt;
`else
   assign o_timeout = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state                  <= IDLE;
         r_last                 <= 2'd3;
         o_grant                <= '0;
         o_done                 <= '0;
         o_fifo_sel             <= '0;
         o_egress_enable        <= 1'b0;
         o_egress_command       <= '0;
         o_egress_flags         <= '0;
         o_egress_address       <= '0;
         o_egress_requester_id  <= '0;
         o_egress_tag           <= '0;
         o_egress_req_dword_cnt <= '0;
         o_busy                 <= 1'b0;
         o_tx_count             <= '0;
`ifdef PCIE_EGRESS_SCHED_TIMEOUT_EN
         r_cnt                  <= '0;
         o_timeout              <= 1'b0;
`endif
      end else begin
         o_done <= '0;
`ifdef PCIE_EGRESS_SCHED_TIMEOUT_EN
         o_timeout <= 1'b0;
`endif
         case (state)
            IDLE: begin
               // A finished still high from the previous packet must drop first.
               if (i_sched_en && found && !i_egress_finished) begin
                  o_grant                <= 4'b0001 << winner;
                  o_fifo_sel             <= winner;
                  o_egress_command       <= i_req_command[winner*8 +: 8];
                  o_egress_flags         <= i_req_flags[winner*14 +: 14];
                  o_egress_address       <= i_req_address[winner*32 +: 32];
                  o_egress_requester_id  <= i_req_requester_id[winner*16 +: 16];
                  o_egress_tag           <= i_req_tag[winner*8 +: 8];
                  o_egress_req_dword_cnt <= i_req_dword_cnt[winner*10 +: 10];
                  o_egress_enable        <= 1'b1;
                  o_busy                 <= 1'b1;
`ifdef PCIE_EGRESS_SCHED_TIMEOUT_EN
                  r_cnt                  <= '0;
`endif
                  state                  <= BUSY;
               end
            end
            BUSY: begin
               if (i_egress_finished) begin
                  o_egress_enable <= 1'b0;
                  state           <= RELEASE;
               end
`ifdef PCIE_EGRESS_SCHED_TIMEOUT_EN
               else if (r_cnt == TIMEOUT - 16'd1) begin
                  o_egress_enable <= 1'b0;
                  o_timeout       <= 1'b1;
                  state           <= RELEASE;
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
`endif
            end
            RELEASE: begin
               if (!i_egress_finished) begin
                  o_done     <= 4'b0001 << o_fifo_sel;
                  o_grant    <= '0;
                  r_last     <= o_fifo_sel;
                  o_tx_count <= o_tx_count + 32'd1;
                  o_busy     <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
